// File: rtl/gpu_sched_pkg.sv
// Shared types and widths for the vector convert scheduler.
package gpu_sched_pkg;

    localparam int unsigned VEC_W    = 64;
    localparam int unsigned COMP_W   = 16;
    localparam int unsigned ID_W_MAX = 3;

    function automatic int unsigned id_width(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Side-band tag travelling alongside the converter latency.
    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [COMP_W-1:0]   c1;
        logic [COMP_W-1:0]   c0;
        logic                valid;
    } tag_t;

endpackage

// File: rtl/vector_convert_scheduler_if.sv
// Requester, converter and rasterizer signals of the vector convert scheduler.
interface vector_convert_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    import gpu_sched_pkg::*;

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*VEC_W-1:0] req_vec;
    logic [NUM_REQ-1:0]       grant;
    logic [VEC_W-1:0]         conv_vec;
    logic                     conv_issue;
    logic [COMP_W-1:0]        conv_x;
    logic [COMP_W-1:0]        conv_y;
    logic                     out_valid;
    logic                     out_ready;
    logic [VEC_W-1:0]         out_vec;
    logic [IdW-1:0]           out_id;

    modport slave (
        input  req, req_vec, conv_x, conv_y, out_ready,
        output grant, conv_vec, conv_issue, out_valid, out_vec, out_id
    );

    modport master (
        output req, req_vec, conv_x, conv_y, out_ready,
        input  grant, conv_vec, conv_issue, out_valid, out_vec, out_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; search starts at the stored pointer, which moves past each winner.
module rr_arbiter
    import gpu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic                             enable,
    output logic [NUM_REQ-1:0]               grant,
    output logic [id_width(NUM_REQ)-1:0]     winner
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic           found;

    always_comb begin : p_arb
        logic [IdW-1:0] idx;
        idx    = '0;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && enable && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IdW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vector_convert_scheduler.sv
// Shares one vector-to-screen converter between requesters, with a credit-protected output FIFO.
// Optional statistics counters are enabled by defining VECTOR_SCHED_STATS_EN.
module vector_convert_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CONV_LAT = 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    vector_convert_scheduler_if.slave   bus
`ifdef VECTOR_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       stat_grant_cnt,
    output logic [15:0]                 stat_stall_cnt
`endif
);

    localparam int unsigned IdW  = id_width(NUM_REQ);
    localparam int unsigned PtrW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     winner;
    logic               credit_ok, enable, grant_any;
    logic [VEC_W-1:0]   win_vec;
    tag_t               tag_in, land;
    tag_t               pipe_q [CONV_LAT+1];

    logic [CntW-1:0]    count_q, count_d, inflight_q, inflight_d;
    logic [PtrW-1:0]    wr_q, rd_q, rd_d;
    logic [VEC_W-1:0]   mem_vec_q [DEPTH];
    logic [IdW-1:0]     mem_id_q [DEPTH];
    logic               push, pop, head_new;
    logic [VEC_W-1:0]   wdata;

    logic [VEC_W-1:0]   conv_vec_q, out_vec_q, out_vec_d;
    logic               conv_issue_q, out_valid_q;
    logic [IdW-1:0]     out_id_q, out_id_d;
    logic               unused_tag_id;

    // Tags already granted still need a slot, so they count against free space.
    assign credit_ok = (32'(count_q) + 32'(inflight_q)) < DEPTH;
    assign enable    = credit_ok && !reset;
    assign grant_any = |grant;
    assign win_vec   = bus.req_vec[32'(winner)*VEC_W +: VEC_W];

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (bus.req),
        .enable(enable),
        .grant (grant),
        .winner(winner)
    );

    always_comb begin
        tag_in.id    = ID_W_MAX'(winner);
        tag_in.c1    = win_vec[31:16];
        tag_in.c0    = win_vec[15:0];
        tag_in.valid = grant_any;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conv_vec_q   <= '0;
            conv_issue_q <= 1'b0;
            for (int unsigned i = 0; i <= CONV_LAT; i++) pipe_q[i] <= '0;
        end else begin
            conv_issue_q <= grant_any;
            if (grant_any) conv_vec_q <= win_vec;
            pipe_q[0] <= tag_in;
            for (int unsigned i = 1; i <= CONV_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign land          = pipe_q[CONV_LAT];
    assign unused_tag_id = ^land.id;
    assign push          = land.valid;
    assign pop           = out_valid_q && bus.out_ready;
    assign wdata         = {bus.conv_x, bus.conv_y, land.c1, land.c0};
    assign rd_d          = rd_q + PtrW'(pop);
    // The landing entry becomes head when nothing else survives this cycle's pop.
    assign head_new      = push && (count_q == (pop ? CntW'(1) : CntW'(0)));

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
        inflight_d = inflight_q;
        if (grant_any && !push)      inflight_d = inflight_q + CntW'(1);
        else if (!grant_any && push) inflight_d = inflight_q - CntW'(1);
        out_vec_d = out_vec_q;
        out_id_d  = out_id_q;
        if (head_new) begin
            out_vec_d = wdata;
            out_id_d  = land.id[IdW-1:0];
        end else if (pop && count_q > CntW'(1)) begin
            out_vec_d = mem_vec_q[rd_d];
            out_id_d  = mem_id_q[rd_d];
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_vec_q[wr_q] <= wdata;
            mem_id_q[wr_q]  <= land.id[IdW-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            inflight_q  <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_id_q    <= '0;
        end else begin
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            wr_q        <= wr_q + PtrW'(push);
            rd_q        <= rd_d;
            out_valid_q <= (count_d != '0);
            out_vec_q   <= out_vec_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.grant      = grant;
    assign bus.conv_vec   = conv_vec_q;
    assign bus.conv_issue = conv_issue_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.out_id     = out_id_q;

`ifdef VECTOR_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
            if (|bus.req && !credit_ok) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grant_cnt[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vector_convert_scheduler.sv
// Bench for vector_convert_scheduler: queue-based reference model plus directed literal checks.
module tb_vector_convert_scheduler;
    import gpu_sched_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int CONV_LAT = 1;
    localparam int DEPTH    = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vector_convert_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef VECTOR_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0] stat_grant_cnt;
    logic [15:0]           stat_stall_cnt;
`endif

    vector_convert_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CONV_LAT(CONV_LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
`ifdef VECTOR_SCHED_STATS_EN
        ,
        .stat_grant_cnt(stat_grant_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    function automatic logic [15:0] fx(logic [15:0] a);
        return (a >> 4) + 16'h0001;
    endfunction
    function automatic logic [15:0] fy(logic [15:0] b);
        return (b >> 4) + 16'h0002;
    endfunction

    // Converter stand-in: CONV_LAT register stages from conv_vec to x/y.
    logic [63:0] cpipe [CONV_LAT];
    always @(posedge clock) begin
        cpipe[0] <= bus.conv_vec;
        for (int i = 1; i < CONV_LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign bus.conv_x = fx(cpipe[CONV_LAT-1][63:48]);
    assign bus.conv_y = fy(cpipe[CONV_LAT-1][47:32]);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: results waiting in the FIFO and tags still in the converter.
    typedef struct {
        int          land;
        logic [63:0] vec;
        int          id;
    } fly_t;
    fly_t        m_fly [$];
    logic [63:0] m_fv [$];
    int          m_fi [$];
    int          m_ptr = 0;
    int          cyc = 0;
    logic [63:0] e_conv = '0, e_out = '0;
    logic        e_issue = 1'b0;
    int          e_id = 0;

    always @(negedge clock) begin : p_model
        int                 credit, w;
        logic [NUM_REQ-1:0] eg;
        logic [63:0]        v;
        if (reset) begin
            m_fly.delete(); m_fv.delete(); m_fi.delete();
            m_ptr = 0; e_conv = '0; e_out = '0; e_issue = 1'b0; e_id = 0;
            check("rst_grant", 64'(bus.grant), 64'd0);
            check("rst_issue", 64'(bus.conv_issue), 64'd0);
            check("rst_conv_vec", bus.conv_vec, 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_vec", bus.out_vec, 64'd0);
            check("rst_out_id", 64'(bus.out_id), 64'd0);
        end else begin
            credit = DEPTH - m_fv.size() - m_fly.size();
            w = -1;
            if (credit > 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (w < 0 && bus.req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
                end
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            check("grant", 64'(bus.grant), 64'(eg));
            check("conv_issue", 64'(bus.conv_issue), 64'(e_issue));
            check("conv_vec", bus.conv_vec, e_conv);
            check("out_valid", 64'(bus.out_valid), 64'(m_fv.size() > 0));
            check("out_vec", bus.out_vec, e_out);
            check("out_id", 64'(bus.out_id), 64'(e_id));
            if (m_fv.size() > 0 && bus.out_ready) begin
                void'(m_fv.pop_front());
                void'(m_fi.pop_front());
            end
            if (m_fly.size() > 0 && m_fly[0].land == cyc) begin
                v = m_fly[0].vec;
                m_fv.push_back({fx(v[63:48]), fy(v[47:32]), v[31:0]});
                m_fi.push_back(m_fly[0].id);
                void'(m_fly.pop_front());
            end
            if (w >= 0) begin
                v = bus.req_vec[w*64 +: 64];
                m_fly.push_back('{land: cyc + 1 + CONV_LAT, vec: v, id: w});
                m_ptr   = (w + 1) % NUM_REQ;
                e_conv  = v;
                e_issue = 1'b1;
            end else begin
                e_issue = 1'b0;
            end
            if (m_fv.size() > 0) begin
                e_out = m_fv[0];
                e_id  = m_fi[0];
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vec(int i, logic [63:0] v);
        bus.req_vec[i*64 +: 64] = v;
    endtask

    initial begin : p_stim
        logic [NUM_REQ-1:0] g;
        int ng, ns;
        logic [15:0] stall0;
        bus.req = '0;
        bus.req_vec = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Single request, hand-computed latency and result.
        step();
        set_vec(0, 64'h0100_0200_0003_0004);
        bus.req = 4'b0001;
        @(negedge clock);
        check("t0_grant", 64'(bus.grant), 64'h1);
        step();
        bus.req = '0;
        @(negedge clock);
        check("t1_issue", 64'(bus.conv_issue), 64'h1);
        check("t1_conv_vec", bus.conv_vec, 64'h0100_0200_0003_0004);
        @(negedge clock);
        check("t2_out_valid", 64'(bus.out_valid), 64'h0);
        @(negedge clock);
        check("t3_out_valid", 64'(bus.out_valid), 64'h1);
        check("t3_out_vec", bus.out_vec, 64'h0011_0022_0003_0004);
        check("t3_out_id", 64'(bus.out_id), 64'h0);

        // All requesters held: rotation starts at 1 and streams without bubbles.
        step();
        bus.req = '1;
        for (int i = 0; i < NUM_REQ; i++) set_vec(i, {$urandom, $urandom});
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check("rr_grant", 64'(bus.grant), 64'(1) << ((1 + k) % NUM_REQ));
            if (k >= 3) begin
                check("rr_out_valid", 64'(bus.out_valid), 64'h1);
                check("rr_out_id", 64'(bus.out_id), 64'((k - 2) % NUM_REQ));
            end
            g = bus.grant;
            step();
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) set_vec(i, {$urandom, $urandom});
        end
        bus.req = '0;
        repeat (8) step();

        // Output stalled: exactly DEPTH grants, then credit starves the arbiter.
        bus.req = '1;
        bus.out_ready = 1'b0;
        ng = 0;
        ns = 0;
        stall0 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
`ifdef VECTOR_SCHED_STATS_EN
            if (k == 0) stall0 = stat_stall_cnt;
`endif
            ng += $countones(bus.grant);
            if (bus.grant == '0) ns++;
            g = bus.grant;
            step();
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) set_vec(i, {$urandom, $urandom});
        end
        @(negedge clock);
        check("stall_grants", 64'(ng), 64'(DEPTH));
        check("stall_grant_zero", 64'(bus.grant), 64'h0);
`ifdef VECTOR_SCHED_STATS_EN
        check("stall_counter", 64'(stat_stall_cnt - stall0), 64'(ns));
`endif
        step();
        bus.req = '0;
        bus.out_ready = 1'b1;
        repeat (10) step();

        // Reset with two tags in flight and two results queued.
        bus.req = '1;
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_rst_valid", 64'(bus.out_valid), 64'h1);
        check("pre_rst_grant", 64'(bus.grant), 64'h0);
        #1 reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        check("mid_rst_vec", bus.out_vec, 64'h0);
        step();
        reset = 1'b0;
        bus.req = 4'b1010;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("post_rst_grant", 64'(bus.grant), 64'h2);

        // Pointer wrap: requester 3 alone, then 0 and 3 together.
        step();
        bus.req = 4'b1000;
        @(negedge clock);
        check("wrap_grant3", 64'(bus.grant), 64'h8);
        step();
        bus.req = 4'b1001;
        @(negedge clock);
        check("wrap_grant0", 64'(bus.grant), 64'h1);
        step();
        bus.req = 4'b1000;
        @(negedge clock);
        g = bus.grant;
        step();
        if (g[3]) bus.req = '0;

        // Randomized traffic with random backpressure; the model checks every cycle.
        repeat (600) begin
            @(negedge clock);
            g = bus.grant;
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && g[i]) begin
                    bus.req[i] = ($urandom_range(0, 3) != 0);
                    set_vec(i, {$urandom, $urandom});
                end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    bus.req[i] = 1'b1;
                    set_vec(i, {$urandom, $urandom});
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        step();
        bus.req = '0;
        bus.out_ready = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
